// File: rtl/lsu_bus_if.sv
// Load/store unit: turns the EX-stage memory request into a handshaked data-bus access
// with byte lanes, load extension, misalign/timeout errors and flush drain.
//
// state | meaning
// IDLE  | no access; accept a new request when valid and not flushed
// REQ   | bus_req_o asserted, waiting for grant
// WAIT  | granted, waiting for rvalid (read data or write ack); may be draining
// RESP  | one-cycle completion pulse towards the pipeline
module lsu_bus_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   input  logic                  req_we_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [2:0]            req_size_i,
   input  logic [31:0]           req_wdata_i,
   input  logic                  flush_i,
   output logic                  hold_flag_o,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_rdata_o,
   output logic                  err_misalign_o,
   output logic                  err_timeout_o,
   output logic [ADDR_W-1:0]     err_addr_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   output logic [DATA_W/8-1:0]   bus_strb_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [DATA_W-1:0]     bus_rdata_i
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [OFF_W-1:0]  off_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              discard_q;
   logic              err_mis_q;
   logic              err_to_q;
   logic [31:0]       rdata_q;

   logic              accept;
   logic              misalign;
   logic              to_hit;
   logic              take_rvalid;
   logic              to_abort;
   logic              in_req;
   logic              busy;
   logic [STRB_W-1:0] strb_base;
   logic [31:0]       wword;
   logic [31:0]       rd_lane;
   logic [31:0]       rd_ext;

   assign accept   = (state == IDLE) && req_valid_i && !flush_i;
   assign misalign = (req_size_i[1:0] == 2'b01) ? req_addr_i[0] :
                     ((req_size_i[1:0] != 2'b00) && (req_addr_i[1:0] != 2'b00));
   assign to_hit   = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   assign take_rvalid = bus_rvalid_i && ((state == WAIT) || ((state == REQ) && bus_gnt_i));
   assign to_abort    = to_hit && (((state == REQ) && !bus_gnt_i && !flush_i) ||
                                   ((state == WAIT) && !bus_rvalid_i));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = misalign ? RESP : REQ;
         REQ: begin
            if (bus_gnt_i) begin
               if (bus_rvalid_i) state_nxt = flush_i ? IDLE : RESP;
               else              state_nxt = WAIT;
            end else if (flush_i) begin
               state_nxt = IDLE;
            end else if (to_hit) begin
               state_nxt = RESP;
            end
         end
         WAIT: if (bus_rvalid_i || to_hit) state_nxt = (discard_q || flush_i) ? IDLE : RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         off_q     <= '0;
         cnt_q     <= '0;
         discard_q <= 1'b0;
         err_mis_q <= 1'b0;
         err_to_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q    <= req_addr_i;
            size_q    <= req_size_i;
            we_q      <= req_we_i;
            wdata_q   <= req_wdata_i;
            off_q     <= req_addr_i[OFF_W-1:0];
            cnt_q     <= '0;
            discard_q <= 1'b0;
            err_mis_q <= misalign;
            err_to_q  <= 1'b0;
            rdata_q   <= '0;
         end else begin
            if ((state == REQ) || (state == WAIT)) cnt_q <= cnt_q + 1'b1;
            // a flush that lands on the grant cycle still owes the bus a response
            if (flush_i && ((state == WAIT) || ((state == REQ) && bus_gnt_i))) discard_q <= 1'b1;
            if (take_rvalid && !we_q) rdata_q <= rd_ext;
            if (to_abort) err_to_q <= 1'b1;
         end
      end
   end

   always_comb begin
      case (size_q[1:0])
         2'b00:   strb_base = STRB_W'(1);
         2'b01:   strb_base = STRB_W'(3);
         default: strb_base = STRB_W'(15);
      endcase
      case (size_q[1:0])
         2'b00:   wword = {4{wdata_q[7:0]}};
         2'b01:   wword = {2{wdata_q[15:0]}};
         default: wword = wdata_q;
      endcase
   end

   assign rd_lane = 32'(bus_rdata_i >> {off_q, 3'b000});

   always_comb begin
      case (size_q[1:0])
         2'b00:   rd_ext = {{24{~size_q[2] & rd_lane[7]}}, rd_lane[7:0]};
         2'b01:   rd_ext = {{16{~size_q[2] & rd_lane[15]}}, rd_lane[15:0]};
         default: rd_ext = rd_lane;
      endcase
   end

   assign in_req = (state == REQ);
   assign busy   = (state == REQ) || (state == WAIT);

   assign bus_req_o   = in_req;
   assign bus_we_o    = in_req && we_q;
   assign bus_addr_o  = in_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign bus_strb_o  = (in_req && we_q) ? (strb_base << off_q) : '0;
   assign bus_wdata_o = (in_req && we_q) ? {(DATA_W/32){wword}} : '0;

   // the accept term is masked by reset so every output reads 0 while rst is low
   assign hold_flag_o    = busy || (accept && rst);
   assign rsp_valid_o    = (state == RESP) && !flush_i;
   assign rsp_rdata_o    = rsp_valid_o ? rdata_q : '0;
   assign err_misalign_o = rsp_valid_o && err_mis_q;
   assign err_timeout_o  = rsp_valid_o && err_to_q;
   assign err_addr_o     = (rsp_valid_o && (err_mis_q || err_to_q)) ? addr_q : '0;
endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: a 32-bit instance (TIMEOUT=4) and a 64-bit instance
// (TIMEOUT=16) driven from shared request/handshake inputs.
module tb_lsu_bus_if;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, flush, bus_gnt, bus_rvalid;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic [31:0] rdata32;
   logic [63:0] rdata64;

   logic        hold, rsp_valid, err_mis, err_to, bus_req, bus_we;
   logic [31:0] rsp_rdata, err_addr, bus_addr, bus_wdata;
   logic [3:0]  bus_strb;

   logic        hold_w, rsp_valid_w, err_mis_w, err_to_w, bus_req_w, bus_we_w;
   logic [31:0] rsp_rdata_w, err_addr_w, bus_addr_w;
   logic [63:0] bus_wdata_w;
   logic [7:0]  bus_strb_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_size_i(req_size), .req_wdata_i(req_wdata), .flush_i(flush), .hold_flag_o(hold),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .err_misalign_o(err_mis),
      .err_timeout_o(err_to), .err_addr_o(err_addr), .bus_req_o(bus_req), .bus_we_o(bus_we),
      .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_strb_o(bus_strb),
      .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(rdata32));

   lsu_bus_if #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) dut64 (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_size_i(req_size), .req_wdata_i(req_wdata), .flush_i(flush), .hold_flag_o(hold_w),
      .rsp_valid_o(rsp_valid_w), .rsp_rdata_o(rsp_rdata_w), .err_misalign_o(err_mis_w),
      .err_timeout_o(err_to_w), .err_addr_o(err_addr_w), .bus_req_o(bus_req_w), .bus_we_o(bus_we_w),
      .bus_addr_o(bus_addr_w), .bus_wdata_o(bus_wdata_w), .bus_strb_o(bus_strb_w),
      .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(rdata64));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
   endtask

   // request at cycle 0, grant+rvalid at cycle 1, response sampled at cycle 2
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, input logic [31:0] rd,
                       output logic [3:0] strb, output logic [31:0] bwd, output logic [31:0] badr,
                       output logic rv, output logic [31:0] rdat);
      drive_req(we, addr, size, wd);
      step();
      bus_gnt = 1'b1; bus_rvalid = 1'b1; rdata32 = rd;
      @(negedge clk);
      strb = bus_strb; bwd = bus_wdata; badr = bus_addr;
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; rdata32 = '0; req_valid = 1'b0;
      @(negedge clk);
      rv = rsp_valid; rdat = rsp_rdata;
      step();
   endtask

   task automatic test_reset();
      req_valid = 1'b1;
      @(negedge clk);
      checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b exp 0", hold); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b exp 0", bus_req); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
      checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h exp 0", bus_addr); end
      checks++; if (err_addr_w !== 32'h0) begin errors++; $display("FAIL reset_err_addr64: got %h exp 0", err_addr_w); end
      req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      step();
   endtask

   task automatic test_load_timing();
      drive_req(1'b0, 32'h100, 3'b010, 32'h0);
      @(negedge clk);
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL lw_hold_c0: got %b exp 1", hold); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL lw_bus_req_c0: got %b exp 0", bus_req); end
      step();
      bus_gnt = 1'b1;
      @(negedge clk);
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL lw_bus_req_c1: got %b exp 1", bus_req); end
      checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL lw_bus_addr: got %h exp 100", bus_addr); end
      checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL lw_bus_we: got %b exp 0", bus_we); end
      checks++; if (bus_strb !== 4'h0) begin errors++; $display("FAIL lw_bus_strb: got %h exp 0", bus_strb); end
      step();
      bus_gnt = 1'b0;
      @(negedge clk);
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL lw_bus_req_c2: got %b exp 0", bus_req); end
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL lw_hold_c2: got %b exp 1", hold); end
      step();
      bus_rvalid = 1'b1; rdata32 = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL lw_hold_c3: got %b exp 1", hold); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_rsp_c3: got %b exp 0", rsp_valid); end
      step();
      bus_rvalid = 1'b0; rdata32 = '0; req_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lw_rsp_c4: got %b exp 1", rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h exp deadbeef", rsp_rdata); end
      checks++; if (hold !== 1'b0) begin errors++; $display("FAIL lw_hold_c4: got %b exp 0", hold); end
      checks++; if ({err_mis, err_to} !== 2'b00) begin errors++; $display("FAIL lw_err: got %b exp 00", {err_mis, err_to}); end
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_rsp_c5: got %b exp 0", rsp_valid); end
      step();
   endtask

   task automatic test_load_ext();
      logic [3:0] s; logic [31:0] wd, ad, rd; logic rv;
      xfer(1'b0, 32'h103, 3'b000, 32'h0, 32'h80000000, s, wd, ad, rv, rd);
      checks++; if (rv !== 1'b1) begin errors++; $display("FAIL lb_latency: got rsp_valid %b exp 1 at cycle 2", rv); end
      checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h exp ffffff80", rd); end
      xfer(1'b0, 32'h103, 3'b100, 32'h0, 32'h80000000, s, wd, ad, rv, rd);
      checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h exp 00000080", rd); end
      xfer(1'b0, 32'h102, 3'b001, 32'h0, 32'h80010000, s, wd, ad, rv, rd);
      checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata: got %h exp ffff8001", rd); end
      xfer(1'b0, 32'h100, 3'b101, 32'h0, 32'h1234ABCD, s, wd, ad, rv, rd);
      checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_rdata: got %h exp 0000abcd", rd); end
      xfer(1'b0, 32'h104, 3'b011, 32'h0, 32'h0BADF00D, s, wd, ad, rv, rd);
      checks++; if ((rd !== 32'h0BADF00D) || (rv !== 1'b1)) begin errors++; $display("FAIL size011_as_w: got %h/%b exp 0badf00d/1", rd, rv); end
   endtask

   task automatic test_store();
      logic [3:0] s; logic [31:0] wd, ad, rd; logic rv;
      xfer(1'b1, 32'h102, 3'b001, 32'h00001234, 32'hFFFFFFFF, s, wd, ad, rv, rd);
      checks++; if (s !== 4'hC) begin errors++; $display("FAIL sh_strb: got %h exp c", s); end
      checks++; if (wd !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h exp 12341234", wd); end
      checks++; if (ad !== 32'h100) begin errors++; $display("FAIL sh_addr: got %h exp 100", ad); end
      checks++; if ((rv !== 1'b1) || (rd !== 32'h0)) begin errors++; $display("FAIL sh_rsp: got %b/%h exp 1/0", rv, rd); end
      xfer(1'b1, 32'h101, 3'b000, 32'hFFFFFFAB, 32'h0, s, wd, ad, rv, rd);
      checks++; if ((s !== 4'h2) || (wd !== 32'hABABABAB)) begin errors++; $display("FAIL sb_lanes: got %h/%h exp 2/abababab", s, wd); end
      xfer(1'b1, 32'h10C, 3'b010, 32'hCAFEF00D, 32'h0, s, wd, ad, rv, rd);
      checks++; if ((s !== 4'hF) || (wd !== 32'hCAFEF00D) || (ad !== 32'h10C)) begin errors++; $display("FAIL sw_lanes: got %h/%h/%h exp f/cafef00d/10c", s, wd, ad); end
   endtask

   task automatic test_bus64();
      drive_req(1'b0, 32'h106, 3'b101, 32'h0);
      step();
      bus_gnt = 1'b1; bus_rvalid = 1'b1; rdata64 = 64'hBEEF_0000_0000_0000;
      @(negedge clk);
      checks++; if ((bus_req_w !== 1'b1) || (bus_addr_w !== 32'h100) || (bus_strb_w !== 8'h0)) begin errors++; $display("FAIL lhu64_bus: got %b/%h/%h exp 1/100/00", bus_req_w, bus_addr_w, bus_strb_w); end
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; rdata64 = '0; req_valid = 1'b0;
      @(negedge clk);
      checks++; if ((rsp_valid_w !== 1'b1) || (rsp_rdata_w !== 32'h0000BEEF)) begin errors++; $display("FAIL lhu64_rsp: got %b/%h exp 1/0000beef", rsp_valid_w, rsp_rdata_w); end
      step();
      drive_req(1'b1, 32'h105, 3'b000, 32'h0000005A);
      step();
      bus_gnt = 1'b1; bus_rvalid = 1'b1;
      @(negedge clk);
      checks++; if ((bus_strb_w !== 8'h20) || (bus_wdata_w !== 64'h5A5A5A5A5A5A5A5A) || (bus_we_w !== 1'b1)) begin errors++; $display("FAIL sb64_lanes: got %h/%h/%b exp 20/5a5a5a5a5a5a5a5a/1", bus_strb_w, bus_wdata_w, bus_we_w); end
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      checks++; if ((rsp_valid_w !== 1'b1) || (hold_w !== 1'b0)) begin errors++; $display("FAIL sb64_rsp: got %b/%b exp 1/0", rsp_valid_w, hold_w); end
      step();
   endtask

   task automatic test_misalign();
      drive_req(1'b0, 32'h101, 3'b010, 32'h0);
      @(negedge clk);
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL mis_hold_c0: got %b exp 1", hold); end
      step();
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if ((rsp_valid !== 1'b1) || (err_mis !== 1'b1)) begin errors++; $display("FAIL mis_rsp: got %b/%b exp 1/1", rsp_valid, err_mis); end
      checks++; if (err_addr !== 32'h101) begin errors++; $display("FAIL mis_err_addr: got %h exp 101", err_addr); end
      checks++; if ((bus_req !== 1'b0) || (hold !== 1'b0) || (rsp_rdata !== 32'h0)) begin errors++; $display("FAIL mis_side: got %b/%b/%h exp 0/0/0", bus_req, hold, rsp_rdata); end
      step();
      drive_req(1'b1, 32'h103, 3'b001, 32'h0);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if ((err_mis !== 1'b1) || (err_addr !== 32'h103)) begin errors++; $display("FAIL mis_sh: got %b/%h exp 1/103", err_mis, err_addr); end
      step();
      drive_req(1'b0, 32'h102, 3'b111, 32'h0);
      step();
      req_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mis_flush_resp: got %b exp 0", rsp_valid); end
      step();
      flush = 1'b0;
      @(negedge clk);
      checks++; if ((rsp_valid !== 1'b0) || (bus_req !== 1'b0)) begin errors++; $display("FAIL mis_flush_after: got %b/%b exp 0/0", rsp_valid, bus_req); end
      step();
   endtask

   task automatic test_timeout();
      drive_req(1'b0, 32'h200, 3'b010, 32'h0);
      step();
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checks++; if ((bus_req !== 1'b1) || (rsp_valid !== 1'b0)) begin errors++; $display("FAIL to_req_c%0d: got %b/%b exp 1/0", c, bus_req, rsp_valid); end
         step();
      end
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if ((rsp_valid !== 1'b1) || (err_to !== 1'b1) || (err_mis !== 1'b0)) begin errors++; $display("FAIL to_rsp: got %b/%b/%b exp 1/1/0", rsp_valid, err_to, err_mis); end
      checks++; if ((err_addr !== 32'h200) || (bus_req !== 1'b0)) begin errors++; $display("FAIL to_addr: got %h/%b exp 200/0", err_addr, bus_req); end
      step();
      bus_rvalid = 1'b1; rdata32 = 32'h11111111;
      @(negedge clk);
      checks++; if ((rsp_valid !== 1'b0) || (hold !== 1'b0)) begin errors++; $display("FAIL to_late_rvalid: got %b/%b exp 0/0", rsp_valid, hold); end
      step();
      bus_rvalid = 1'b0; rdata32 = '0; flush = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_idle: got %b exp 0", rsp_valid); end
      step();
      flush = 1'b0;
      step();
   endtask

   task automatic test_flush();
      drive_req(1'b0, 32'h300, 3'b010, 32'h0);
      step();
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0; flush = 1'b1; req_valid = 1'b0;
      @(negedge clk);
      checks++; if (hold_w !== 1'b1) begin errors++; $display("FAIL fw_hold_flush: got %b exp 1", hold_w); end
      step();
      flush = 1'b0;
      for (int c = 3; c <= 4; c++) begin
         @(negedge clk);
         checks++; if ((hold_w !== 1'b1) || (rsp_valid_w !== 1'b0)) begin errors++; $display("FAIL fw_drain_c%0d: got %b/%b exp 1/0", c, hold_w, rsp_valid_w); end
         step();
      end
      bus_rvalid = 1'b1; rdata64 = 64'h55;
      @(negedge clk);
      checks++; if ((hold_w !== 1'b1) || (rsp_valid_w !== 1'b0)) begin errors++; $display("FAIL fw_rvalid: got %b/%b exp 1/0", hold_w, rsp_valid_w); end
      step();
      bus_rvalid = 1'b0; rdata64 = '0;
      @(negedge clk);
      checks++; if ((hold_w !== 1'b0) || (rsp_valid_w !== 1'b0)) begin errors++; $display("FAIL fw_after: got %b/%b exp 0/0", hold_w, rsp_valid_w); end
      step();
      drive_req(1'b0, 32'h400, 3'b010, 32'h0);
      step();
      flush = 1'b1; req_valid = 1'b0;
      step();
      flush = 1'b0;
      @(negedge clk);
      checks++; if ((bus_req !== 1'b0) || (hold !== 1'b0) || (rsp_valid !== 1'b0)) begin errors++; $display("FAIL fr_withdraw: got %b/%b/%b exp 0/0/0", bus_req, hold, rsp_valid); end
      step();
      drive_req(1'b0, 32'h500, 3'b010, 32'h0); flush = 1'b1;
      @(negedge clk);
      checks++; if (hold !== 1'b0) begin errors++; $display("FAIL fi_hold: got %b exp 0", hold); end
      step();
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fi_blocked: got %b exp 0", bus_req); end
      step();
   endtask

   task automatic test_reset_mid();
      drive_req(1'b0, 32'h600, 3'b010, 32'h0);
      step();
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      @(negedge clk);
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rm_wait_hold: got %b exp 1", hold); end
      rst = 1'b0;
      #1;
      checks++; if ({hold, bus_req, rsp_valid, err_mis, err_to} !== 5'b0) begin errors++; $display("FAIL rm_outputs: got %b exp 00000", {hold, bus_req, rsp_valid, err_mis, err_to}); end
      checks++; if ({rsp_rdata, err_addr, bus_addr} !== 96'h0) begin errors++; $display("FAIL rm_buses: got %h exp 0", {rsp_rdata, err_addr, bus_addr}); end
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      bus_rvalid = 1'b1; rdata32 = 32'h77777777;
      @(negedge clk);
      checks++; if ((rsp_valid !== 1'b0) || (bus_req !== 1'b0)) begin errors++; $display("FAIL rm_late_rvalid: got %b/%b exp 0/0", rsp_valid, bus_req); end
      step();
      bus_rvalid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp: got %b exp 0", rsp_valid); end
      step();
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
      flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; rdata32 = '0; rdata64 = '0;
      test_reset();
      test_load_timing();
      test_load_ext();
      test_store();
      test_bus64();
      test_misalign();
      test_timeout();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
